// File: rtl/qracc_pkg.sv
// qracc_pkg: shared types and constants for the QRAcc SRAM port arbiter.
package qracc_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT_RD} qracc_arb_state_t;

    localparam int NUM_SRAM_REQUESTERS = 2;

endpackage

// File: rtl/qracc_sram_arbiter.sv
// qracc_sram_arbiter: round-robin sharing of the single QRAcc SRAM port between host and loader.
module qracc_sram_arbiter
    import qracc_pkg::*;
#(
    parameter int numRows = 128,
    parameter int numCols = 32,
    localparam int AW = $clog2(numRows)
) (
    input  logic                                   clk,
    input  logic                                   nrst,
    input  logic [NUM_SRAM_REQUESTERS-1:0]         req_wr_i,
    input  logic [NUM_SRAM_REQUESTERS-1:0]         req_valid_i,
    output logic [NUM_SRAM_REQUESTERS-1:0]         req_ready_o,
    input  logic [NUM_SRAM_REQUESTERS*AW-1:0]      req_addr_i,
    input  logic [NUM_SRAM_REQUESTERS*numCols-1:0] req_wdata_i,
    output logic [NUM_SRAM_REQUESTERS-1:0]         rsp_valid_o,
    output logic [numCols-1:0]                     rsp_rdata_o,
    output logic                                   sram_rq_wr_o,
    output logic                                   sram_rq_valid_o,
    input  logic                                   sram_rq_ready_i,
    output logic [AW-1:0]                          sram_addr_o,
    output logic [numCols-1:0]                     sram_wr_data_o,
    input  logic                                   sram_rd_valid_i,
    input  logic [numCols-1:0]                     sram_rd_data_i
);

    qracc_arb_state_t state;
    logic             last_grant;
    logic             owner;
    logic             gnt;

    // On a tie the port that did not win last time gets the grant.
    always_comb begin
        gnt         = &req_valid_i ? ~last_grant : req_valid_i[1];
        req_ready_o = (state == ARB_IDLE && |req_valid_i) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state           <= ARB_IDLE;
            last_grant      <= 1'b1;
            owner           <= 1'b0;
            sram_rq_wr_o    <= 1'b0;
            sram_rq_valid_o <= 1'b0;
            sram_addr_o     <= '0;
            sram_wr_data_o  <= '0;
            rsp_valid_o     <= '0;
            rsp_rdata_o     <= '0;
        end else begin
            rsp_valid_o <= '0;
            case (state)
                ARB_IDLE: if (|req_valid_i) begin
                    state           <= ARB_ISSUE;
                    sram_rq_valid_o <= 1'b1;
                    sram_rq_wr_o    <= req_wr_i[gnt];
                    sram_addr_o     <= gnt ? req_addr_i[AW +: AW] : req_addr_i[0 +: AW];
                    sram_wr_data_o  <= gnt ? req_wdata_i[numCols +: numCols] : req_wdata_i[0 +: numCols];
                    owner           <= gnt;
                    last_grant      <= gnt;
                end
                ARB_ISSUE: if (sram_rq_ready_i) begin
                    sram_rq_valid_o <= 1'b0;
                    state           <= sram_rq_wr_o ? ARB_IDLE : ARB_WAIT_RD;
                end
                ARB_WAIT_RD: if (sram_rd_valid_i) begin
                    rsp_rdata_o        <= sram_rd_data_i;
                    rsp_valid_o[owner] <= 1'b1;
                    state              <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
